cordic_polar_post: RTL
======================

CORDIC_POLAR_POST -- requirements
Module: cordic_polar_post

Interface
REQ-001 Parameter WL, 24: magnitude width, s7.17.
REQ-002 Parameter DEPTH, 4: output FIFO depth (power of 2, >=2).
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port in_valid, input, 1: mag_in/phase_in valid this cycle; no stall path exists upstream.
REQ-006 Port mag_in, input, WL: uncompensated CORDIC magnitude, s7.17.
REQ-007 Port phase_in, input, 24: phase, s2.21; pi = 6588397.
REQ-008 Port out_valid, output, 1: FIFO head valid.
REQ-009 Port out_ready, input, 1: consumer accepts head when out_valid && out_ready.
REQ-010 Port mag_out, output, WL: gain-compensated magnitude, s7.17.
REQ-011 Port dphase_out, output, 24: wrapped phase difference, s2.21.
REQ-012 Port first_out, output, 1: entry has no predecessor phase.
REQ-013 Port overflow, output, 1: sticky; a sample was dropped.
REQ-014 Port level, output, $clog2(DEPTH)+1: current FIFO occupancy.

Function
REQ-015 Gain constant KINV = 79594 (round(0.607252935 * 2^17)), unsigned 18-bit.
REQ-016 mag_out = (max(mag_in,0) * KINV + 2^16) >> 17; negative mag_in clamps to 0; no saturation needed (KINV < 2^17).
REQ-017 d = phase_in - prev_phase, computed at 25 bits; if d > 6588397, subtract 13176794; if d < -6588397, add 13176794; result truncated to 24 bits.
REQ-018 prev_phase updates to phase_in on every in_valid sample, including samples dropped by the FIFO.
REQ-019 First in_valid sample after reset: dphase_out = 0, first_out = 1; all later samples first_out = 0.
REQ-020 Pipeline: in_valid sampled at edge k registers product/raw difference (S1); rounding, clamp, and wrap at edge k+1 (S2); FIFO write at edge k+2; outputs visible after edge k+2 when FIFO was empty.
REQ-021 Pipeline valid bits are independent; back-to-back in_valid sustains 1 sample/cycle.
REQ-022 FIFO is DEPTH-entry circular; pointers wrap modulo DEPTH; level = writes - reads.
REQ-023 out_valid = (level != 0); mag_out/dphase_out/first_out reflect the head entry and hold while out_valid && !out_ready.
REQ-024 Pop when out_valid && out_ready; head advances at that edge.
REQ-025 Write is accepted if level < DEPTH, or if level == DEPTH and a pop occurs in the same cycle.
REQ-026 Write with level == DEPTH and no pop: sample dropped, FIFO unchanged, overflow set at that edge.
REQ-027 Simultaneous push and pop at level 0 < L < DEPTH: level unchanged, order preserved.
REQ-028 overflow is cleared only by rst.
REQ-029 Entries leave in arrival order; no reordering or duplication.

Reset
REQ-030 While rst = 1 at an edge: S1/S2 valid bits cleared, FIFO emptied (level = 0), prev_phase = 0, first-sample flag re-armed, overflow = 0.
REQ-031 Outputs after reset: out_valid = 0, mag_out = 0, dphase_out = 0, first_out = 0, overflow = 0, level = 0.
REQ-032 Reset mid-stream discards all in-flight and buffered samples; in_valid during rst is ignored.

Verification
REQ-033 Reset: drive garbage with in_valid = 1 under rst -> all outputs 0 after the first post-reset edge.
REQ-034 mag_in = 131072, phase_in = 0, out_ready = 1 -> out_valid after 3 edges, mag_out = 79594, dphase_out = 0, first_out = 1; mag_in = -5 -> mag_out = 0.
REQ-035 Phases 0 then 1000 -> second entry dphase_out = 1000, first_out = 0.
REQ-036 Phases 6000000 then -6000000 -> dphase_out = 1176794; reverse order -> -1176794.
REQ-037 out_ready = 0, 6 consecutive in_valid samples -> level saturates at 4, overflow = 1 at the 5th write edge; out_ready = 1 -> exactly samples 1-4 drain in order; overflow stays 1.
REQ-038 Full FIFO with out_ready = 1 and a write in the same cycle -> write accepted, level stays 4, overflow stays 0.

Source files
------------

// File: rtl/cordic_polar_post_if.sv
// Bus bundle for cordic_polar_post.
// master: the environment drives the sample stream and out_ready, and observes the FIFO head.
// slave : the block receives the sample stream and drives the FIFO head, overflow and level.
interface cordic_polar_post_if #(
    parameter int unsigned WL    = 24,
    parameter int unsigned DEPTH = 4
) ();
    localparam int unsigned LW = $clog2(DEPTH) + 1;

    logic          in_valid;
    logic [WL-1:0] mag_in;
    logic [23:0]   phase_in;
    logic          out_valid;
    logic          out_ready;
    logic [WL-1:0] mag_out;
    logic [23:0]   dphase_out;
    logic          first_out;
    logic          overflow;
    logic [LW-1:0] level;

    modport master (
        output in_valid, mag_in, phase_in, out_ready,
        input  out_valid, mag_out, dphase_out, first_out, overflow, level
    );

    modport slave (
        input  in_valid, mag_in, phase_in, out_ready,
        output out_valid, mag_out, dphase_out, first_out, overflow, level
    );
endinterface

// File: rtl/cordic_polar_post.sv
// CORDIC polar post-processor. It takes the raw CORDIC magnitude and phase, removes the CORDIC gain
// from the magnitude, forms the wrapped phase difference to the previous sample, and buffers the
// results in a small output FIFO.
// Ports:
//   clk             - rising-edge clock
//   rst             - synchronous active-high reset
//   bus.in_valid    - sample valid; upstream cannot stall
//   bus.mag_in      - uncompensated magnitude, s7.17
//   bus.phase_in    - phase, s2.21
//   bus.out_ready   - consumer accepts the FIFO head
//   bus.out_valid   - FIFO head valid
//   bus.mag_out     - gain-compensated magnitude, s7.17
//   bus.dphase_out  - wrapped phase difference, s2.21
//   bus.first_out   - head entry has no predecessor phase
//   bus.overflow    - sticky; set when a sample was dropped
//   bus.level       - FIFO occupancy
module cordic_polar_post #(
    parameter int unsigned WL    = 24,
    parameter int unsigned DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    cordic_polar_post_if.slave bus
);
    localparam int unsigned PW = WL + 18;
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    localparam logic [17:0]        KINV   = 18'd79594;
    localparam logic signed [24:0] PI_P   = 25'sd6588397;
    localparam logic signed [24:0] PI_N   = -25'sd6588397;
    localparam logic signed [24:0] TWO_PI = 25'sd13176794;

    // Phase history
    logic [23:0] prev_phase;
    logic        first_pend;

    // Stage 1: product and raw difference
    logic               s1_valid;
    logic               s1_first;
    logic [PW-1:0]      s1_prod;
    logic signed [24:0] s1_diff;

    // Stage 2: rounded magnitude and wrapped difference
    logic          s2_valid;
    logic          s2_first;
    logic [WL-1:0] s2_mag;
    logic [23:0]   s2_dphase;

    // FIFO storage
    logic [WL-1:0]    mem_mag [DEPTH];
    logic [23:0]      mem_dph [DEPTH];
    logic [DEPTH-1:0] mem_first;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    level;
    logic             overflow;

    // Stage-1 combinational terms
    logic [WL-1:0]      mag_pos_c;
    logic [PW-1:0]      prod_c;
    logic signed [24:0] diff_c;

    // Negative magnitudes clamp to zero before the multiply, which gives the same result as
    // clamping the product.
    always_comb begin
        mag_pos_c = bus.mag_in[WL-1] ? '0 : bus.mag_in;
        prod_c    = PW'(mag_pos_c) * PW'(KINV);
        diff_c    = $signed({bus.phase_in[23], bus.phase_in}) - $signed({prev_phase[23], prev_phase});
    end

    // Stage-2 combinational terms
    logic [PW-1:0]      rnd_c;
    logic [WL-1:0]      mag_c;
    logic signed [24:0] wrap_c;
    logic [23:0]        dphase_c;

    // Round half up at bit 17; KINV < 2^17 so the result always fits in WL bits.
    always_comb begin
        rnd_c = s1_prod + PW'(65536);
        mag_c = WL'(rnd_c >> 17);
        if (s1_diff > PI_P) begin
            wrap_c = s1_diff - TWO_PI;
        end else if (s1_diff < PI_N) begin
            wrap_c = s1_diff + TWO_PI;
        end else begin
            wrap_c = s1_diff;
        end
        dphase_c = s1_first ? '0 : 24'(wrap_c);
    end

    // FIFO control
    logic pop_c;
    logic full_c;
    logic push_c;
    logic drop_c;

    // A full FIFO still accepts a write when the head is popped on the same edge.
    always_comb begin
        pop_c  = (level != '0) && bus.out_ready;
        full_c = (level == LW'(DEPTH));
        push_c = s2_valid && (!full_c || pop_c);
        drop_c = s2_valid && full_c && !pop_c;
    end

    // Phase history and pipeline registers; prev_phase follows every sample, even dropped ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_phase <= '0;
            first_pend <= 1'b1;
            s1_valid   <= 1'b0;
            s1_first   <= 1'b0;
            s1_prod    <= '0;
            s1_diff    <= '0;
            s2_valid   <= 1'b0;
            s2_first   <= 1'b0;
            s2_mag     <= '0;
            s2_dphase  <= '0;
        end else begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                prev_phase <= bus.phase_in;
                first_pend <= 1'b0;
                s1_first   <= first_pend;
                s1_prod    <= prod_c;
                s1_diff    <= diff_c;
            end
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_first  <= s1_first;
                s2_mag    <= mag_c;
                s2_dphase <= dphase_c;
            end
        end
    end

    // Circular FIFO with sticky overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            overflow  <= 1'b0;
            mem_first <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_mag[i] <= '0;
                mem_dph[i] <= '0;
            end
        end else begin
            if (push_c) begin
                mem_mag[wr_ptr]   <= s2_mag;
                mem_dph[wr_ptr]   <= s2_dphase;
                mem_first[wr_ptr] <= s2_first;
                wr_ptr            <= wr_ptr + AW'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push_c && !pop_c) begin
                level <= level + LW'(1);
            end else if (pop_c && !push_c) begin
                level <= level - LW'(1);
            end
            if (drop_c) begin
                overflow <= 1'b1;
            end
        end
    end

    // Head entry is read straight from the storage registers.
    assign bus.out_valid  = (level != '0);
    assign bus.mag_out    = mem_mag[rd_ptr];
    assign bus.dphase_out = mem_dph[rd_ptr];
    assign bus.first_out  = mem_first[rd_ptr];
    assign bus.overflow   = overflow;
    assign bus.level      = level;
endmodule
